// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 32-bit Han-Carlson adder, with per-requester carry chaining.
// Define ADDER_ARBITER_SUB_EN to enable subtraction via req_op; otherwise every operation is an add.

module adder_arbiter_hc32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   localparam int unsigned W  = 32;
   localparam int unsigned LV = 6;

   logic [W-1:0] p0;
   logic [W-1:0] carry_c;
   logic         unused_p;

   assign p0 = a ^ b;

   // Level 0 folds cin into bit 0; levels 1-5 build odd-bit prefixes; level 6 fills even bits.
   for (genvar lv = 0; lv <= LV; lv++) begin : g_lvl
      logic [W-1:0] gg;
      logic [W-1:0] pp;
      if (lv == 0) begin : g_pre
         assign gg = (a & b) | {{(W-1){1'b0}}, p0[0] & cin};
         assign pp = p0;
      end else begin : g_pfx
         for (genvar i = 0; i < W; i++) begin : g_bit
            localparam int D = (lv == LV) ? 1 : (1 << (lv - 1));
            localparam bit COMBINE = (lv == LV) ? ((i % 2 == 0) && (i >= 2))
                                                : ((i % 2 == 1) && (i >= D));
            if (COMBINE) begin : g_op
               assign gg[i] = g_lvl[lv-1].gg[i] | (g_lvl[lv-1].pp[i] & g_lvl[lv-1].gg[i-D]);
               assign pp[i] = g_lvl[lv-1].pp[i] & g_lvl[lv-1].pp[i-D];
            end else begin : g_pass
               assign gg[i] = g_lvl[lv-1].gg[i];
               assign pp[i] = g_lvl[lv-1].pp[i];
            end
         end
      end
   end

   assign carry_c  = g_lvl[LV].gg;
   assign sum      = p0 ^ {carry_c[W-2:0], cin};
   assign cout     = carry_c[W-1];
   assign unused_p = ^g_lvl[LV].pp;
endmodule

module adder_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   input  logic [1:0]  req_op,
   input  logic [1:0]  req_chain,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_sum,
   output logic        rsp_cout
);
   localparam int unsigned W = 32;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t       state_q, state_d;
   logic         last_q, last_d;
   logic         grant_q, grant_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic         chain_q, chain_d;
   logic [1:0]   carry_q, carry_d;
   logic [1:0]   rsp_valid_q, rsp_valid_d;
   logic [W-1:0] sum_q, sum_d;
   logic         cout_q, cout_d;

   logic         pick_c;
   logic         accept_c;
   logic         sub_c;
   logic         add_cin_c;
   logic [W-1:0] add_b_c;
   logic [W-1:0] add_sum_c;
   logic         add_cout_c;

`ifdef ADDER_ARBITER_SUB_EN
   logic         op_q, op_d;
   assign sub_c = op_q;
`else
   logic         unused_op;
   assign sub_c     = 1'b0;
   assign unused_op = ^req_op;
`endif

   // Round-robin: a lone requester wins; on a tie the one not granted last time wins.
   assign pick_c    = (req_valid == 2'b11) ? ~last_q : req_valid[1];
   assign req_ready = (rst_n && (state_q == IDLE) && (|req_valid)) ? (2'b01 << pick_c) : 2'b00;
   assign accept_c  = |(req_valid & req_ready);

   assign add_cin_c = chain_q ? carry_q[grant_q] : sub_c;
   assign add_b_c   = b_q ^ {W{sub_c}};

   adder_arbiter_hc32 u_add (
      .a    (a_q),
      .b    (add_b_c),
      .cin  (add_cin_c),
      .sum  (add_sum_c),
      .cout (add_cout_c)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_d     = grant_q;
      a_d         = a_q;
      b_d         = b_q;
      chain_d     = chain_q;
      carry_d     = carry_q;
      rsp_valid_d = rsp_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
`ifdef ADDER_ARBITER_SUB_EN
      op_d        = op_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               a_d     = pick_c ? req_a[2*W-1:W] : req_a[W-1:0];
               b_d     = pick_c ? req_b[2*W-1:W] : req_b[W-1:0];
               chain_d = req_chain[pick_c];
`ifdef ADDER_ARBITER_SUB_EN
               op_d    = req_op[pick_c];
`endif
               grant_d = pick_c;
               last_d  = pick_c;
               state_d = EXEC;
            end
         end
         EXEC: begin
            sum_d            = add_sum_c;
            cout_d           = add_cout_c;
            carry_d[grant_q] = add_cout_c;
            rsp_valid_d      = 2'b01 << grant_q;
            state_d          = RESP;
         end
         RESP: begin
            if (rsp_ready[grant_q]) begin
               rsp_valid_d = 2'b00;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset discards any in-flight operation and clears the carry history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         grant_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         chain_q     <= 1'b0;
         carry_q     <= 2'b00;
         rsp_valid_q <= 2'b00;
         sum_q       <= '0;
         cout_q      <= 1'b0;
`ifdef ADDER_ARBITER_SUB_EN
         op_q        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         grant_q     <= grant_d;
         a_q         <= a_d;
         b_q         <= b_d;
         chain_q     <= chain_d;
         carry_q     <= carry_d;
         rsp_valid_q <= rsp_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
`ifdef ADDER_ARBITER_SUB_EN
         op_q        <= op_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized bench for adder_arbiter against a transaction-level arithmetic/round-robin model.
// Honours ADDER_ARBITER_SUB_EN the same way the design does.

module tb_adder_arbiter;
`ifdef ADDER_ARBITER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, req_op, req_chain, rsp_valid, rsp_ready;
   logic [63:0] req_a, req_b;
   logic [31:0] rsp_sum;
   logic        rsp_cout;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [1:0]  m_carry;
   logic        m_last;

   adder_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .req_chain (req_chain),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] rnd32();
      case ($urandom % 4)
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // One offer cycle plus, if granted, the full EXEC/RESP exchange. Entered and left at a negedge.
   task automatic do_op(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] op,
                        input logic [1:0] ch, input int hold, output logic gw);
      logic        w;
      logic        sub, cin;
      logic [31:0] a, b, bb;
      logic [32:0] r;
      req_valid = v;
      req_a     = {a1, a0};
      req_b     = {b1, b0};
      req_op    = op;
      req_chain = ch;
      rsp_ready = 2'b00;
      gw        = 1'b0;
      #1;
      if (v == 2'b00) begin
         check("idle_ready", req_ready, 0);
         @(posedge clk);
         @(negedge clk);
         check("idle_rsp_valid", rsp_valid, 0);
         return;
      end
      w  = (v == 2'b11) ? ~m_last : v[1];
      gw = w;
      check("req_ready", req_ready, 2'b01 << w);
      a   = w ? a1 : a0;
      b   = w ? b1 : b0;
      sub = SUB_EN && op[w];
      bb  = sub ? ~b : b;
      cin = ch[w] ? m_carry[w] : sub;
      r   = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
      m_carry[w] = r[32];
      m_last     = w;
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = 2'($urandom) & ~(2'b01 << w);
      #1;
      check("exec_rsp_valid", rsp_valid, 0);
      check("exec_ready", req_ready, 0);
      @(negedge clk);
      check("resp_valid", rsp_valid, 2'b01 << w);
      check("resp_sum", rsp_sum, r[31:0]);
      check("resp_cout", rsp_cout, r[32]);
      for (int k = 0; k < hold; k++) begin
         req_valid = 2'($urandom);
         rsp_ready = 2'($urandom) & ~(2'b01 << w);
         @(negedge clk);
         check("hold_valid", rsp_valid, 2'b01 << w);
         check("hold_sum", rsp_sum, r[31:0]);
         check("hold_ready", req_ready, 0);
      end
      req_valid = 2'b00;
      rsp_ready = (2'b01 << w) | (2'($urandom) & ~(2'b01 << w));
      @(negedge clk);
      check("post_valid", rsp_valid, 0);
      rsp_ready = 2'b00;
   endtask

   // Accept an op for requester 0, then pulse reset while it is in EXEC.
   task automatic reset_in_exec();
      req_valid = 2'b01;
      req_a     = {32'h0, 32'hFFFF_FFFF};
      req_b     = {32'h0, 32'h0000_0001};
      req_op    = 2'b00;
      req_chain = 2'b00;
      #1;
      check("rst_pre_ready", req_ready, 2'b01);
      @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 2'b11;
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_sum", rsp_sum, 0);
      check("rst_rsp_cout", rsp_cout, 0);
      check("rst_req_ready", req_ready, 0);
      m_carry = 2'b00;
      m_last  = 1'b1;
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 2'b00;
      repeat (3) begin
         @(negedge clk);
         check("rst_no_rsp", rsp_valid, 0);
      end
   endtask

   initial begin
      logic gw;
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_a     = '0;
      req_b     = '0;
      req_op    = 2'b00;
      req_chain = 2'b00;
      rsp_ready = 2'b00;
      m_carry   = 2'b00;
      m_last    = 1'b1;
      #1;
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_sum", rsp_sum, 0);
      check("reset_rsp_cout", rsp_cout, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Both requesters continuously valid from reset: grants alternate starting with 0.
      for (int k = 0; k < 4; k++) begin
         do_op(2'b11, rnd32(), rnd32(), rnd32(), rnd32(), 2'($urandom), 2'b00, 0, gw);
         check("rr_grant", 64'(gw), 64'(k % 2));
      end

      do_op(2'b01, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 2'b00, 2'b00, 0, gw);
      check("wrap_sum", rsp_sum, 32'h0);
      check("wrap_cout", rsp_cout, 1);

      do_op(2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 0, gw);
      check("chain_sum", rsp_sum, 32'h1);
      check("chain_cout", rsp_cout, 0);

      do_op(2'b10, 32'h0, 32'h0, 32'h5, 32'h7, 2'b10, 2'b00, 0, gw);
      check("sub_sum", rsp_sum, SUB_EN ? 32'hFFFF_FFFE : 32'h0000_000C);
      check("sub_cout", rsp_cout, 0);

      do_op(2'b11, rnd32(), rnd32(), rnd32(), rnd32(), 2'($urandom), 2'($urandom), 5, gw);

      reset_in_exec();
      do_op(2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01, 0, gw);
      check("post_rst_chain_sum", rsp_sum, 32'h0);
      check("post_rst_chain_cout", rsp_cout, 0);

      for (int k = 0; k < 200; k++) begin
         do_op(2'($urandom), rnd32(), rnd32(), rnd32(), rnd32(), 2'($urandom), 2'($urandom),
               int'($urandom_range(0, 3)), gw);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits to match the shared 32-bit Han-Carlson adder.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  2  per-requester operation request; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; a request is taken when req_valid[i] and req_ready[i] are both high on a clock edge.
REQ-006 req_a, req_b  input  2x32 each  per-requester operands, packed as [63:32] for requester 1 and [31:0] for requester 0.
REQ-007 req_op  input  2  per-requester operation: 0 = add, 1 = subtract (a-b).
REQ-008 req_chain  input  2  per-requester chain flag: 1 = use that requester's stored carry as the carry-in.
REQ-009 rsp_valid  output  2  per-requester result valid.
REQ-010 rsp_ready  input  2  per-requester result accept.
REQ-011 rsp_sum  output  32  result, shared by both requesters.
REQ-012 rsp_cout  output  1  carry-out, shared by both requesters.

Function
REQ-013 The block SHALL instantiate exactly one 32-bit Han-Carlson adder and share it between the two requesters.
REQ-014 The FSM SHALL have three states: IDLE, EXEC and RESP; it resets to IDLE.
REQ-015 In IDLE, req_ready SHALL be one-hot toward the arbitration winner, or 0 when no request is pending; req_ready SHALL be 0 in EXEC and RESP.
REQ-016 Arbitration SHALL be round-robin:
- if only one requester is valid, that requester is granted;
- if both are valid, the requester not granted last time is granted;
- the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-017 On accept, the block SHALL capture the granted requester's a, b, op and chain into internal registers, record the grant index, and move IDLE->EXEC.
REQ-018 In EXEC, the adder SHALL be driven from the captured registers:
- cin = stored carry of the granted requester if chain=1;
- otherwise cin = op;
- b is inverted when op=1.
REQ-019 In EXEC, sum and cout SHALL be registered into rsp_sum and rsp_cout, cout SHALL also be written to the granted requester's carry register, and the FSM SHALL move EXEC->RESP.
REQ-020 In RESP, rsp_valid[grant] SHALL be 1 and the other rsp_valid bit 0; rsp_sum and rsp_cout SHALL hold stable until rsp_ready[grant] is sampled high, after which the FSM moves RESP->IDLE.
REQ-021 Latency SHALL be: accept at edge N, rsp_valid high after edge N+1, earliest new accept at edge N+3.
REQ-022 rsp_ready on the non-granted bit SHALL be ignored; a req_valid deasserted while not ready SHALL be ignored, with no request latched.
REQ-023 Carry registers SHALL update only in EXEC and only for the granted requester.
REQ-024 Arithmetic SHALL be modulo 2^32, and cout SHALL be the raw adder carry. For subtract, cout=1 means no borrow.

Reset
REQ-025 While rst_n is low, the block SHALL asynchronously force:
- state = IDLE, last-grant = 1, both carry registers = 0;
- rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, req_ready = 0.
REQ-026 A reset asserted in EXEC or RESP SHALL discard the in-flight operation; no rsp_valid SHALL appear after rst_n deasserts until a new accept.
REQ-027 On the first edge after rst_n deasserts, the block SHALL be ready to accept.

Configuration
REQ-028 Macro ADDER_ARBITER_SUB_EN, when defined, SHALL enable subtraction exactly as in REQ-018.
REQ-029 Without ADDER_ARBITER_SUB_EN:
- req_op SHALL remain a port but be ignored;
- every operation SHALL be an add;
- cin SHALL be 0, or the stored carry when chain=1;
- b SHALL never be inverted.

Verification
REQ-030 Requester 0 submits a=0xFFFFFFFF, b=0x00000001, add, chain=0 -> rsp_valid[0] high after 2 edges, rsp_sum=0x00000000, rsp_cout=1.
REQ-031 Requester 0 then submits a=0, b=0, add, chain=1 -> rsp_sum=0x00000001, rsp_cout=0, confirming carry chaining.
REQ-032 Both requesters hold req_valid=1 continuously for 4 operations from reset -> grants alternate 0,1,0,1, and each result returns on the matching rsp_valid bit.
REQ-033 With SUB_EN, requester 1 submits a=5, b=7, subtract -> rsp_sum=0xFFFFFFFE, rsp_cout=0; without SUB_EN, the same stimulus gives rsp_sum=0x0000000C, rsp_cout=0.
REQ-034 rsp_ready is held low for 5 cycles in RESP -> rsp_sum is stable, req_ready=00 throughout, and req_ready reasserts on the cycle after the handshake.
REQ-035 rst_n pulsed low during EXEC -> all outputs go to 0 immediately, no rsp_valid follows, and a chained add afterwards uses carry=0.
